// File: rtl/line_bus_arbiter.sv
// Multi-channel line bus arbiter: captures per-channel write/read requests,
// grants one channel at a time (fixed priority or round-robin) and runs a
// single command/response transaction on the shared downstream port.
module line_bus_arbiter #(
  parameter int NCH      = 2,
  parameter int ARB_MODE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH-1:0]       ch_wreq,
  input  logic [NCH*32-1:0]    ch_waddr,
  input  logic [NCH*128-1:0]   ch_wdata,
  input  logic [NCH*16-1:0]    ch_wmask,
  output logic [NCH-1:0]       ch_wdone,
  input  logic [NCH-1:0]       ch_rreq,
  input  logic [NCH*32-1:0]    ch_raddr,
  output logic [127:0]         ch_rdata,
  output logic [NCH-1:0]       ch_rvalid,
  output logic [NCH-1:0]       ch_ovf,
  output logic                 m_cmd_valid,
  input  logic                 m_cmd_ready,
  output logic                 m_cmd_we,
  output logic [31:0]          m_cmd_addr,
  output logic [127:0]         m_cmd_wdata,
  output logic [15:0]          m_cmd_wmask,
  input  logic                 m_wresp,
  input  logic                 m_rvalid,
  input  logic [127:0]         m_rdata
);

  localparam int GW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t          state_q, state_d;
  logic [NCH-1:0]  wpend, rpend, wbusy, rbusy, wacc, racc;
  logic [31:0]     waddr_r [NCH];
  logic [127:0]    wdata_r [NCH];
  logic [15:0]     wmask_r [NCH];
  logic [31:0]     raddr_r [NCH];
  logic [GW-1:0]   gnt_q, last_q, sel, idx;
  logic            we_q, found, hs, wr_done, rd_done;

  assign m_cmd_valid = (state_q == ISSUE);
  assign hs          = (state_q == ISSUE) && m_cmd_ready;
  assign wr_done     = (state_q == WAIT) && we_q && m_wresp;
  assign rd_done     = (state_q == WAIT) && !we_q && m_rvalid;

  // Busy/accept decode: a request is taken only if its slot is neither pending nor in flight
  always_comb begin
    wbusy = '0;
    rbusy = '0;
    for (int i = 0; i < NCH; i++) begin
      wbusy[i] = (state_q == WAIT) && we_q && (gnt_q == GW'(i));
      rbusy[i] = (state_q == WAIT) && !we_q && (gnt_q == GW'(i));
    end
    wacc = ch_wreq & ~wpend & ~wbusy;
    racc = ch_rreq & ~rpend & ~rbusy;
  end

  // Grant search: lowest index, or rotating start just after the last grant
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    for (int k = 0; k < NCH; k++) begin
      if (ARB_MODE == 0) idx = GW'(k);
      else               idx = GW'((int'(last_q) + 1 + k) % NCH);
      if (!found && (wpend[idx] || rpend[idx])) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  // Next-state logic for the single-transaction FSM
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (found) state_d = ISSUE;
      ISSUE:   if (m_cmd_ready) state_d = WAIT;
      WAIT:    if (wr_done || rd_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Pending bits and sticky overflow flags
  always_ff @(posedge clk) begin
    if (rst) begin
      wpend  <= '0;
      rpend  <= '0;
      ch_ovf <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (hs && (gnt_q == GW'(i))) begin
          if (we_q) wpend[i] <= 1'b0;
          else      rpend[i] <= 1'b0;
        end
        if (wacc[i])         wpend[i]  <= 1'b1;
        else if (ch_wreq[i]) ch_ovf[i] <= 1'b1;
        if (racc[i])         rpend[i]  <= 1'b1;
        else if (ch_rreq[i]) ch_ovf[i] <= 1'b1;
      end
    end
  end

  // Per-channel request capture (data only, no reset needed)
  always_ff @(posedge clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (wacc[i]) begin
        waddr_r[i] <= ch_waddr[32*i +: 32];
        wdata_r[i] <= ch_wdata[128*i +: 128];
        wmask_r[i] <= ch_wmask[16*i +: 16];
      end
      if (racc[i]) raddr_r[i] <= ch_raddr[32*i +: 32];
    end
  end

  // Grant bookkeeping and command register load; write wins within a channel
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_q       <= '0;
      last_q      <= GW'(NCH - 1);
      we_q        <= 1'b0;
      m_cmd_we    <= 1'b0;
      m_cmd_addr  <= '0;
      m_cmd_wdata <= '0;
      m_cmd_wmask <= '0;
    end else if ((state_q == IDLE) && found) begin
      gnt_q  <= sel;
      last_q <= sel;
      we_q   <= wpend[sel];
      if (wpend[sel]) begin
        m_cmd_we    <= 1'b1;
        m_cmd_addr  <= waddr_r[sel];
        m_cmd_wdata <= wdata_r[sel];
        m_cmd_wmask <= wmask_r[sel];
      end else begin
        m_cmd_we    <= 1'b0;
        m_cmd_addr  <= raddr_r[sel];
        m_cmd_wdata <= '0;
        m_cmd_wmask <= 16'hffff;
      end
    end
  end

  // Completion pulses and read data return
  always_ff @(posedge clk) begin
    if (rst) begin
      ch_wdone  <= '0;
      ch_rvalid <= '0;
      ch_rdata  <= '0;
    end else begin
      ch_wdone  <= '0;
      ch_rvalid <= '0;
      if (wr_done) ch_wdone[gnt_q] <= 1'b1;
      if (rd_done) begin
        ch_rvalid[gnt_q] <= 1'b1;
        ch_rdata         <= m_rdata;
      end
    end
  end

endmodule
